// File: rtl/brlite_tx_arbiter.sv
// brlite_tx_arbiter: round-robin sharing of the single BrLite output port.
// Requesters raise req_i with a stable payload; the winner's payload is
// latched, offered on br_req_o/br_data_o, and the winner gets a one-cycle
// ack_o (plus err_o when the watchdog gives up on an unacknowledged send).

package brlite_pkg;

    // Payload carried from a requester to the BrLite router local port.
    typedef struct packed {
        logic [7:0]  service;
        logic [31:0] payload;
    } brlite_out_t;

endpackage

// Handshake semantics: br_req_o is a level "valid" that rises one cycle
// after a grant and stays high with br_data_o frozen until br_ack_i is
// sampled high in SEND (or the watchdog expires); the requester side is a
// level req_i answered by a single-cycle ack_o, after which the requester
// drops req_i on the edge that samples ack_o.
module brlite_tx_arbiter
    import brlite_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_REQ-1:0]           req_i,
    input  brlite_out_t [N_REQ-1:0]    data_i,
    output logic [N_REQ-1:0]           ack_o,
    output logic [N_REQ-1:0]           err_o,
    output logic [$clog2(N_REQ)-1:0]   grant_o,
    output logic                       busy_o,
    input  logic                       br_local_busy_i,
    output logic                       br_req_o,
    input  logic                       br_ack_i,
    output brlite_out_t                br_data_o
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [GW-1:0] PTR_LAST = GW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    // state_q is kept as a plain named register so checkers can bind to it.
    state_t          state_q;
    logic [GW-1:0]   rr_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            found;
    logic [GW-1:0]   winner;
    logic            timeout;
    logic [GW-1:0]   ptr_next;

    // Pick the first requesting index at or after rr_ptr, wrapping explicitly
    // so non-power-of-two N_REQ never lands on a nonexistent requester.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_i[idx[GW-1:0]]) begin
                found  = 1'b1;
                winner = idx[GW-1:0];
            end
        end
    end

    // Watchdog expiry and the pointer that follows the current winner.
    always_comb begin
        timeout  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
        ptr_next = (grant_o == PTR_LAST) ? '0 : grant_o + 1'b1;
    end

    assign busy_o = (state_q != IDLE);

    // Arbitration FSM with all BrLite and requester outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            grant_o   <= '0;
            br_req_o  <= 1'b0;
            br_data_o <= '0;
            ack_o     <= '0;
            err_o     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found && !br_local_busy_i) begin
                        br_data_o <= data_i[winner];
                        grant_o   <= winner;
                        br_req_o  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (br_ack_i) begin
                        br_req_o       <= 1'b0;
                        ack_o          <= '0;
                        ack_o[grant_o] <= 1'b1;
                        state_q        <= ACK;
                    end else if (timeout) begin
                        br_req_o       <= 1'b0;
                        ack_o          <= '0;
                        ack_o[grant_o] <= 1'b1;
                        err_o          <= '0;
                        err_o[grant_o] <= 1'b1;
                        state_q        <= ACK;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ACK: begin
                    ack_o    <= '0;
                    err_o    <= '0;
                    rr_ptr_q <= ptr_next;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brlite_tx_arbiter.sv
// Directed-plus-random bench for brlite_tx_arbiter (3 requesters, 8-cycle
// watchdog). Expected grants, payloads and timing come from a transaction
// level model: winner = first requesting index from a pointer modulo N.
module tb_brlite_tx_arbiter;
    import brlite_pkg::*;

    localparam int N  = 3;
    localparam int TO = 8;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic [N-1:0]        req_i;
    brlite_out_t [N-1:0] data_i;
    logic [N-1:0]        ack_o;
    logic [N-1:0]        err_o;
    logic [1:0]          grant_o;
    logic                busy_o;
    logic                br_local_busy_i;
    logic                br_req_o;
    logic                br_ack_i;
    brlite_out_t         br_data_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int model_ptr = 0;

    brlite_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_i           (req_i),
        .data_i          (data_i),
        .ack_o           (ack_o),
        .err_o           (err_o),
        .grant_o         (grant_o),
        .busy_o          (busy_o),
        .br_local_busy_i (br_local_busy_i),
        .br_req_o        (br_req_o),
        .br_ack_i        (br_ack_i),
        .br_data_o       (br_data_o)
    );

    // Clock and cycle counter.
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Hard time bound so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rule: first requesting index scanning from ptr modulo N.
    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic randomize_data();
        for (int k = 0; k < N; k++) data_i[k] = {8'($urandom), 32'($urandom)};
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        req_i = '0;
        br_ack_i = 1'b0;
        br_local_busy_i = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        model_ptr = 0;
    endtask

    // One full transfer: optional local-busy hold, grant, ack at SEND edge
    // ack_at (timeout at edge TO when ack_at > TO), ACK cycle, back to IDLE.
    task automatic xfer(input logic [N-1:0] reqs, input int busy_cycles, input int ack_at,
                        input bit drop_req, input bit scramble, output int win, output int gcyc);
        brlite_out_t   exp_data;
        logic [N-1:0]  exp_ack;
        int            w;
        int            e;
        bit            done;
        w = pick(reqs, model_ptr);
        req_i = reqs;
        br_local_busy_i = (busy_cycles > 0);
        for (int b = 0; b < busy_cycles; b++) begin
            br_ack_i = 1'($urandom_range(0, 1));
            step();
            chk("busy_hold_br_req", br_req_o, 0);
            chk("busy_hold_busy", busy_o, 0);
        end
        br_local_busy_i = 1'b0;
        br_ack_i = 1'($urandom_range(0, 1));
        exp_data = data_i[w];
        step();
        gcyc = cyc;
        chk("grant_index", grant_o, w);
        chk("grant_br_req", br_req_o, 1);
        chk("grant_busy", busy_o, 1);
        chk("grant_data", br_data_o, exp_data);
        chk("grant_no_ack", ack_o, 0);
        exp_ack = '0;
        exp_ack[w] = 1'b1;
        done = 1'b0;
        e = 1;
        while (!done) begin
            br_ack_i = (e == ack_at);
            if (scramble) randomize_data();
            if (drop_req) req_i[w] = 1'b0;
            step();
            if (e == ack_at || e == TO) begin
                chk("done_ack", ack_o, exp_ack);
                chk("done_err", err_o, (e == ack_at) ? '0 : exp_ack);
                chk("done_br_req", br_req_o, 0);
                done = 1'b1;
            end else begin
                chk("send_br_req", br_req_o, 1);
                chk("send_no_ack", ack_o, 0);
                chk("send_data_held", br_data_o, exp_data);
            end
            e++;
        end
        br_ack_i = 1'b0;
        req_i[w] = 1'b0;
        step();
        chk("idle_ack_clear", ack_o, 0);
        chk("idle_err_clear", err_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_br_req", br_req_o, 0);
        chk("idle_data_held", br_data_o, exp_data);
        model_ptr = (w + 1) % N;
        win = w;
    endtask

    initial begin
        int w;
        int g;
        int prev_g;
        data_i = '0;
        apply_reset();

        // Reset values.
        chk("reset_br_req", br_req_o, 0);
        chk("reset_ack", ack_o, 0);
        chk("reset_err", err_o, 0);
        chk("reset_grant", grant_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_data", br_data_o, 0);

        // Single request, ack two cycles after br_req_o.
        data_i = '0;
        data_i[0].payload = 32'hDEADBEEF;
        xfer(3'b001, 0, 2, 1'b0, 1'b0, w, g);
        chk("single_payload", br_data_o.payload, 32'hDEADBEEF);
        chk("single_grant", grant_o, 0);

        // Local busy blocks grant for 10 cycles.
        randomize_data();
        xfer(3'b010, 10, 1, 1'b0, 1'b0, w, g);
        chk("busy_grant", grant_o, 1);

        // Asynchronous reset in the middle of SEND.
        randomize_data();
        req_i = 3'b001;
        step();
        chk("rst_pre_br_req", br_req_o, 1);
        step();
        step();
        rst_ni = 1'b0;
        #1;
        chk("rst_async_br_req", br_req_o, 0);
        chk("rst_async_ack", ack_o, 0);
        chk("rst_async_busy", busy_o, 0);
        chk("rst_async_grant", grant_o, 0);
        step();
        chk("rst_hold_ack", ack_o, 0);
        rst_ni = 1'b1;
        model_ptr = 0;
        xfer(3'b001, 0, 3, 1'b0, 1'b0, w, g);
        chk("rst_after_grant", grant_o, 0);

        // Round robin with all requesters active and immediate ack.
        apply_reset();
        prev_g = 0;
        for (int i = 0; i < 6; i++) begin
            randomize_data();
            xfer(3'b111, 0, 1, 1'b0, 1'b0, w, g);
            chk("rr_sequence", grant_o, i % 3);
            if (i > 0) chk("rr_period", g - prev_g, 3);
            prev_g = g;
        end

        // Watchdog expiry, then ack on the expiry cycle (ack wins, no err).
        randomize_data();
        xfer(3'($urandom_range(1, 7)), 0, 20, 1'b0, 1'b0, w, g);
        randomize_data();
        xfer(3'($urandom_range(1, 7)), 0, TO, 1'b0, 1'b0, w, g);

        // Payload stability with data_i scrambled and req dropped in SEND.
        randomize_data();
        xfer(3'b001, 0, 5, 1'b1, 1'b1, w, g);

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            randomize_data();
            xfer(3'($urandom_range(1, 7)), $urandom_range(0, 3), $urandom_range(1, 10),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w, g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
